// File: rtl/dest_pkg.sv
// Shared types and constants for the destination load sequencer.
package dest_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  localparam int DEST_PTR_W       = 2;
  localparam int DEFAULT_NUM_DEST = 3;
  localparam int DEST_CNT_W       = 4;

endpackage

// File: rtl/dest_ptr_ring.sv
// Round-robin destination pointer: forced load, advance with wrap, one-hot decode.
// Zero latency on outputs (registered pointer); no backpressure, caller gates load/advance.
module dest_ptr_ring
  import dest_pkg::*;
#(
  parameter int NUM_DEST = DEFAULT_NUM_DEST
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DEST_PTR_W-1:0] i_load_val,
  input  logic                  i_adv,
  output logic [DEST_PTR_W-1:0] o_ptr,
  output logic                  o_is_last,
  output logic [NUM_DEST-1:0]   o_onehot
);

  localparam logic [DEST_PTR_W-1:0] LAST_IDX = DEST_PTR_W'(NUM_DEST - 1);

  logic [DEST_PTR_W-1:0] r_ptr;

  // Out-of-range forced values fall back to entry 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= (i_load_val > LAST_IDX) ? '0 : i_load_val;
    end else if (i_adv) begin
      r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
    end
  end

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      o_onehot[i] = (r_ptr == DEST_PTR_W'(i));
    end
  end

  assign o_ptr     = r_ptr;
  assign o_is_last = (r_ptr == LAST_IDX);

endmodule

// File: rtl/dest_load_sequencer.sv
// Sequences loads round-robin into the destination group, holding WE for WRITE_CYCLES cycles.
// Ready is combinational; one load per WRITE_CYCLES+1 cycles, SEL_SET stalls acceptance.
module dest_load_sequencer
  import dest_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_DEST     = DEFAULT_NUM_DEST,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LDD_VALID,
  output logic                  LDD_READY,
  input  logic [DATA_W-1:0]     LDD_DATA,
  input  logic                  SEL_SET,
  input  logic [DEST_PTR_W-1:0] SEL_VAL,
  output logic [NUM_DEST-1:0]   WE,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DEST_PTR_W-1:0] PTR,
  output logic                  GROUP_DONE
);

  state_e                  r_state, w_state_nxt;
  logic [DEST_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_DEST-1:0]     r_we, w_we_nxt;
  logic [DATA_W-1:0]       r_wdata, w_wdata_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_ptr_load, w_ptr_adv, w_is_last;
  logic [NUM_DEST-1:0]     w_onehot;
  logic [DEST_PTR_W-1:0]   w_ptr;

  dest_ptr_ring #(.NUM_DEST(NUM_DEST)) u_ptr_ring (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_ptr_load),
    .i_load_val (SEL_VAL),
    .i_adv      (w_ptr_adv),
    .o_ptr      (w_ptr),
    .o_is_last  (w_is_last),
    .o_onehot   (w_onehot)
  );

  assign LDD_READY = (r_state == ST_IDLE) && !SEL_SET && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    w_done_nxt  = 1'b0;
    w_ptr_load  = 1'b0;
    w_ptr_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Pointer force has priority; a concurrent load waits one cycle.
        if (SEL_SET) begin
          w_ptr_load = 1'b1;
        end else if (LDD_VALID) begin
          w_wdata_nxt = LDD_DATA;
          w_we_nxt    = w_onehot;
          w_cnt_nxt   = DEST_CNT_W'(WRITE_CYCLES - 1);
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_cnt == '0) begin
          w_we_nxt    = '0;
          w_state_nxt = ST_IDLE;
          w_ptr_adv   = 1'b1;
          w_done_nxt  = w_is_last;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign WE         = r_we;
  assign WDATA      = r_wdata;
  assign PTR        = w_ptr;
  assign GROUP_DONE = r_done;

endmodule

// File: tb/tb_dest_load_sequencer.sv
// Bench: vector table and hand sequences, then a random stream against a behavioural model.
module tb_dest_load_sequencer;

  localparam int ND = 3;
  localparam int NLOADS = 1000;

  logic       CLK = 1'b0;
  logic       rst  [2];
  logic       vld  [2];
  logic [7:0] dat  [2];
  logic       sel  [2];
  logic [1:0] selv [2];
  logic       rdy  [2];
  logic [2:0] we   [2];
  logic [7:0] wd   [2];
  logic [1:0] ptr  [2];
  logic       gd   [2];

  always #5 CLK = ~CLK;

  dest_load_sequencer #(.DATA_W(8), .NUM_DEST(ND), .WRITE_CYCLES(1)) u_dut_wc1 (
    .CLK(CLK), .RST(rst[0]), .LDD_VALID(vld[0]), .LDD_READY(rdy[0]), .LDD_DATA(dat[0]),
    .SEL_SET(sel[0]), .SEL_VAL(selv[0]), .WE(we[0]), .WDATA(wd[0]), .PTR(ptr[0]),
    .GROUP_DONE(gd[0])
  );

  dest_load_sequencer #(.DATA_W(8), .NUM_DEST(ND), .WRITE_CYCLES(3)) u_dut_wc3 (
    .CLK(CLK), .RST(rst[1]), .LDD_VALID(vld[1]), .LDD_READY(rdy[1]), .LDD_DATA(dat[1]),
    .SEL_SET(sel[1]), .SEL_VAL(selv[1]), .WE(we[1]), .WDATA(wd[1]), .PTR(ptr[1]),
    .GROUP_DONE(gd[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic [1:0] sv;
    logic       rdy;
    logic [2:0] we;
    logic [7:0] wd;
    logic [1:0] p;
    logic       gd;
  } vec_t;

  vec_t tbl[17];

  // Behavioural model state for the random phase
  int         m_busy [2];
  logic [1:0] m_ptr  [2];
  logic [2:0] m_we   [2];
  logic [7:0] m_wd   [2];
  logic       m_gd   [2];
  logic [2:0] prev_we[2];
  int         acc    [2];
  int         wr_obs [2];
  int         gd_cnt [2];
  int         wr_last[2];
  int         q0[$];
  int         q1[$];

  task automatic rand_cycle(input bit drain);
    bit m_rdy, hs;
    int ent, exp_ent, item;
    for (int k = 0; k < 2; k++) begin
      sel[k]  = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
      selv[k] = 2'($urandom_range(0, 3));
      vld[k]  = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
      dat[k]  = 8'($urandom_range(0, 255));
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      m_rdy = (m_busy[k] == 0) && !sel[k];
      chk($sformatf("rand_rdy%0d", k), 32'(rdy[k]), 32'(m_rdy));
      hs = m_rdy && vld[k];
      m_gd[k] = 1'b0;
      if (m_busy[k] > 0) begin
        m_busy[k]--;
        if (m_busy[k] == 0) begin
          m_we[k]  = '0;
          m_gd[k]  = (int'(m_ptr[k]) == ND - 1);
          m_ptr[k] = 2'((int'(m_ptr[k]) + 1) % ND);
        end
      end else if (sel[k]) begin
        m_ptr[k] = (int'(selv[k]) < ND) ? selv[k] : 2'd0;
      end else if (hs) begin
        m_wd[k]   = dat[k];
        m_we[k]   = 3'(1 << m_ptr[k]);
        m_busy[k] = wc_of(k);
        acc[k]++;
        item = (int'(m_ptr[k]) << 8) | int'(dat[k]);
        if (k == 0) q0.push_back(item); else q1.push_back(item);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rand_out%0d", k), {19'd0, we[k], wd[k], ptr[k], gd[k]},
          {19'd0, m_we[k], m_wd[k], m_ptr[k], m_gd[k]});
      chk($sformatf("rand_onehot%0d", k), 32'($onehot0(we[k])), 32'd1);
      if (gd[k]) gd_cnt[k]++;
      if (we[k] != 3'b000 && prev_we[k] == 3'b000) begin
        wr_obs[k]++;
        ent = (we[k] == 3'b001) ? 0 : (we[k] == 3'b010) ? 1 : 2;
        if (ent == ND - 1) wr_last[k]++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          chk($sformatf("rand_extra_write%0d", k), 32'd1, 32'd0);
        end else begin
          item = (k == 0) ? q0.pop_front() : q1.pop_front();
          exp_ent = item >> 8;
          chk($sformatf("rand_entry%0d", k), {ent[15:0], 8'd0, wd[k]}, {exp_ent[15:0], 8'd0, item[7:0]});
        end
      end
      prev_we[k] = we[k];
    end
  endtask

  initial begin
    int we_cycles, rdy_low, done_seen, cyc;

    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 2'd0, 1'b1, 3'b001, 8'hA1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'hB2, 1'b0, 2'd0, 1'b0, 3'b000, 8'hA1, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 8'hB2, 1'b0, 2'd0, 1'b1, 3'b010, 8'hB2, 2'd1, 1'b0};
    tbl[3]  = '{1'b1, 8'hC3, 1'b0, 2'd0, 1'b0, 3'b000, 8'hB2, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 8'hC3, 1'b0, 2'd0, 1'b1, 3'b100, 8'hC3, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 8'hC3, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 3'b000, 8'hC3, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 8'h77, 1'b1, 2'd2, 1'b0, 3'b000, 8'hC3, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 8'h77, 1'b0, 2'd0, 1'b1, 3'b100, 8'h77, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 8'h77, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 3'b000, 8'h77, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 3'b000, 8'h77, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 8'h3C, 1'b0, 2'd0, 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 8'h99, 1'b1, 2'd0, 1'b0, 3'b000, 8'h3C, 2'd2, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 3'b000, 8'h3C, 2'd2, 1'b0};
    tbl[15] = '{1'b1, 8'h55, 1'b0, 2'd0, 1'b1, 3'b100, 8'h55, 2'd2, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 8'h55, 2'd0, 1'b1};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; vld[k] = 1'b0; dat[k] = 8'h00; sel[k] = 1'b0; selv[k] = 2'd0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_rdy%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("reset_outs%0d", k), {19'd0, we[k], wd[k], ptr[k], gd[k]}, 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    chk("post_reset_rdy", 32'(rdy[0]), 32'd1);

    // Table: WRITE_CYCLES=1 instance
    for (int i = 0; i < 17; i++) begin
      vld[0] = tbl[i].v; dat[0] = tbl[i].d; sel[0] = tbl[i].s; selv[0] = tbl[i].sv;
      #1;
      chk($sformatf("vec%0d_rdy", i), 32'(rdy[0]), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d_outs", i), {19'd0, we[0], wd[0], ptr[0], gd[0]},
          {19'd0, tbl[i].we, tbl[i].wd, tbl[i].p, tbl[i].gd});
    end
    vld[0] = 1'b0; sel[0] = 1'b0;

    // Three-cycle write of 0x5A into entry 0
    vld[1] = 1'b1; dat[1] = 8'h5A;
    #1;
    chk("wc3_accept_rdy", 32'(rdy[1]), 32'd1);
    tick();
    vld[1] = 1'b0; dat[1] = 8'hFF;
    we_cycles = 0; rdy_low = 0; done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (we[1] == 3'b001) we_cycles++;
      if (!rdy[1]) rdy_low++;
      if (gd[1]) done_seen++;
      if (i == 0) chk("wc3_first_we", {24'd0, we[1], wd[1][4:0]}, {24'd0, 3'b001, 5'h1A});
      tick();
    end
    chk("wc3_we_cycles", 32'(we_cycles), 32'd3);
    chk("wc3_rdy_low", 32'(rdy_low), 32'd3);
    chk("wc3_done", 32'(done_seen), 32'd0);
    chk("wc3_ptr_wdata", {22'd0, ptr[1], wd[1]}, {22'd0, 2'd1, 8'h5A});

    // Reset in the second cycle of a three-cycle write
    vld[1] = 1'b1; dat[1] = 8'h66;
    tick();
    vld[1] = 1'b0;
    chk("midrst_we_before", 32'(we[1]), 32'(3'b010));
    tick();
    #2;
    rst[1] = 1'b1;
    #1;
    chk("midrst_async", {19'd0, we[1], wd[1], ptr[1], gd[1]}, 32'd0);
    chk("midrst_rdy", 32'(rdy[1]), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gd[1] || we[1] != 3'b000) done_seen++;
    end
    chk("midrst_quiet", 32'(done_seen), 32'd0);
    rst[1] = 1'b0;
    vld[1] = 1'b1; dat[1] = 8'h11;
    #1;
    chk("midrst_rdy_after", 32'(rdy[1]), 32'd1);
    tick();
    vld[1] = 1'b0;
    chk("midrst_first_load", {21'd0, we[1], wd[1]}, {21'd0, 3'b001, 8'h11});

    // Random stream on both instances from a fresh reset
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_ptr[k] = 2'd0; m_we[k] = 3'b000; m_wd[k] = 8'h00; m_gd[k] = 1'b0;
      prev_we[k] = 3'b000; acc[k] = 0; wr_obs[k] = 0; gd_cnt[k] = 0; wr_last[k] = 0;
    end
    cyc = 0;
    while ((acc[0] < NLOADS || acc[1] < NLOADS) && cyc < 40000) begin
      rand_cycle(1'b0);
      cyc++;
    end
    if (cyc >= 40000) chk("rand_budget", 32'(cyc), 32'd0);
    for (int i = 0; i < 10; i++) rand_cycle(1'b1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rand_no_loss%0d", k), 32'(wr_obs[k]), 32'(acc[k]));
      chk($sformatf("rand_q_empty%0d", k), 32'((k == 0) ? q0.size() : q1.size()), 32'd0);
      chk($sformatf("rand_gd_count%0d", k), 32'(gd_cnt[k]), 32'(wr_last[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
